// File: rtl/pkt_read_scheduler.sv
// pkt_read_scheduler: SP/WRR packet scheduler that pulls queue addresses, issues SRAM reads
// and frames the returned data with sop/vld/eop.
module pkt_read_scheduler #(
    parameter int NUM_PRIO = 8,
    parameter int PRIO_W   = 3,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int WGT_W    = 5,
    parameter int RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [NUM_PRIO*WGT_W-1:0] wrr_weight,
    input  logic                      ready,
    input  logic [NUM_PRIO-1:0]       prepared,
    output logic [NUM_PRIO-1:0]       grant,
    output logic                      addr_req,
    input  logic [ADDR_W-1:0]         addr_in,
    input  logic                      addr_last,
    output logic                      sram_en,
    output logic [ADDR_W-1:0]         sram_addr,
    input  logic [DATA_W-1:0]         sram_rdata,
    output logic                      rd_sop,
    output logic                      rd_vld,
    output logic                      rd_eop,
    output logic [DATA_W-1:0]         rd_data,
    output logic [PRIO_W-1:0]         rd_prio,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, SOP, FETCH, DRAIN} state_t;
    localparam logic [PRIO_W-1:0] LAST = PRIO_W'(NUM_PRIO - 1);

    state_t state;
    logic [PRIO_W-1:0] ptr, sp_win, wrr_win, win, idx;
    logic [WGT_W-1:0] cnt, wgt, eff;
    logic [WGT_W-1:0] wgts [NUM_PRIO];
    logic [WGT_W:0] n;
    logic done;
    logic [RD_LAT-1:0] vld_sr, last_sr;

    always_comb begin
        sp_win = '0;
        wrr_win = '0;
        idx = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            wgts[i] = wrr_weight[i*WGT_W +: WGT_W];
            if (prepared[i]) sp_win = PRIO_W'(i);
        end
        // walk from farthest to nearest so the slot closest below the pointer wins
        for (int i = NUM_PRIO - 1; i >= 0; i--) begin
            idx = PRIO_W'((int'(ptr) + NUM_PRIO - i) % NUM_PRIO);
            if (prepared[idx]) wrr_win = idx;
        end
        win = mode ? wrr_win : sp_win;
        wgt = wgts[win];
        eff = wgt == '0 ? WGT_W'(1) : wgt;
        n = (win == ptr ? {1'b0, cnt} : '0) + (WGT_W + 1)'(1);
        done = n >= {1'b0, eff};
    end

    assign addr_req  = state == SOP || (state == FETCH && ready);
    assign sram_en   = addr_req;
    assign sram_addr = sram_en ? addr_in : '0;
    assign rd_vld    = vld_sr[RD_LAT-1];
    assign rd_eop    = rd_vld && last_sr[RD_LAT-1];
    assign rd_data   = rd_vld ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            rd_prio <= '0;
            rd_sop  <= 1'b0;
            busy    <= 1'b0;
            ptr     <= LAST;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (ready && |prepared) begin
                    state   <= SOP;
                    rd_sop  <= 1'b1;
                    busy    <= 1'b1;
                    grant   <= NUM_PRIO'(1) << win;
                    rd_prio <= win;
                    ptr     <= !mode ? LAST : done ? (win == '0 ? LAST : win - PRIO_W'(1)) : win;
                    cnt     <= (!mode || done) ? '0 : n[WGT_W-1:0];
                end
                SOP: begin
                    rd_sop <= 1'b0;
                    state  <= addr_last ? DRAIN : FETCH;
                end
                FETCH: if (addr_req && addr_last) state <= DRAIN;
                DRAIN: if (rd_eop) begin
                    state   <= IDLE;
                    grant   <= '0;
                    rd_prio <= '0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // {valid, last} travel alongside the SRAM access so framing lines up with returned data
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= RD_LAT'({vld_sr, sram_en});
            last_sr <= RD_LAT'({last_sr, addr_req && addr_last});
        end
    end
endmodule

// File: tb/tb_pkt_read_scheduler.sv
// tb_pkt_read_scheduler: directed and randomized packet traffic checked against a
// packet-level model of arbitration, fetch timing and read-data framing.
module tb_pkt_read_scheduler;
    localparam int NP = 8, PW = 3, AW = 12, DW = 64, WW = 5, LAT = 3, RING = 16;

    logic clk = 1'b0, rst = 1'b1, mode = 1'b0, ready = 1'b0, addr_last = 1'b0;
    logic [NP*WW-1:0] wrr_weight = '0;
    logic [NP-1:0] prepared = '0, grant;
    logic addr_req, sram_en, rd_sop, rd_vld, rd_eop, busy;
    logic [AW-1:0] addr_in = '0, sram_addr;
    logic [DW-1:0] sram_rdata = '0, rd_data;
    logic [PW-1:0] rd_prio;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int q [NP][$];
    int wt [NP];
    int m_ptr = NP - 1, m_cnt = 0;
    logic e_busy, e_sop, e_req;
    logic [NP-1:0] e_grant;
    logic [PW-1:0] e_prio;
    logic sv [RING];
    logic sl [RING];
    logic [DW-1:0] sd [RING];
    logic [DW-1:0] sram_q [RING];

    pkt_read_scheduler #(.NUM_PRIO(NP), .PRIO_W(PW), .ADDR_W(AW), .DATA_W(DW), .WGT_W(WW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .mode(mode), .wrr_weight(wrr_weight), .ready(ready), .prepared(prepared),
        .grant(grant), .addr_req(addr_req), .addr_in(addr_in), .addr_last(addr_last), .sram_en(sram_en),
        .sram_addr(sram_addr), .sram_rdata(sram_rdata), .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_eop(rd_eop),
        .rd_data(rd_data), .rd_prio(rd_prio), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return {32'(a) * 32'h9E3779B1, 20'hA5A5A, a};
    endfunction

    function automatic logic [NP-1:0] prep();
        logic [NP-1:0] r = '0;
        for (int p = 0; p < NP; p++) r[p] = q[p].size() != 0;
        return r;
    endfunction

    // winner from the queue contents: SP = highest index, WRR = first non-empty at/below pointer
    function automatic int pick();
        for (int i = 0; i < NP; i++) begin
            int p;
            p = mode ? (m_ptr - i + NP) % NP : NP - 1 - i;
            if (q[p].size() != 0) return p;
        end
        return -1;
    endfunction

    task automatic grant_upd(input int w);
        int n, lim;
        if (!mode) begin
            m_ptr = NP - 1;
            m_cnt = 0;
        end else begin
            n = (w == m_ptr ? m_cnt : 0) + 1;
            lim = wt[w] == 0 ? 1 : wt[w];
            if (n >= lim) begin
                m_ptr = (w + NP - 1) % NP;
                m_cnt = 0;
            end else begin
                m_ptr = w;
                m_cnt = n;
            end
        end
    endtask

    task automatic set_wt();
        for (int p = 0; p < NP; p++) wrr_weight[p*WW +: WW] = WW'(wt[p]);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic fetch_exp(input logic last);
        int s;
        s = (cyc + LAT) % RING;
        sv[s] = 1'b1;
        sl[s] = last;
        sd[s] = mem(addr_in);
    endtask

    task automatic clear_all();
        for (int i = 0; i < RING; i++) begin
            sv[i] = 1'b0;
            sl[i] = 1'b0;
        end
    endtask

    task automatic step();
        int s;
        s = cyc % RING;
        prepared = prep();
        sram_rdata = sram_q[s];
        @(negedge clk);
        chk("busy", busy, e_busy);
        chk("grant", grant, e_grant);
        chk("rd_prio", rd_prio, e_prio);
        chk("rd_sop", rd_sop, e_sop);
        chk("addr_req", addr_req, e_req);
        chk("sram_en", sram_en, e_req);
        if (e_req) chk("sram_addr", sram_addr, addr_in);
        chk("rd_vld", rd_vld, sv[s]);
        chk("rd_eop", rd_eop, sv[s] & sl[s]);
        if (sv[s]) chk("rd_data", rd_data, sd[s]);
        sram_q[(cyc + LAT) % RING] = sram_en ? mem(sram_addr) : {$urandom, $urandom};
        sv[s] = 1'b0;
        sl[s] = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        e_busy = 0; e_grant = '0; e_prio = '0; e_sop = 0; e_req = 0;
        for (int i = 0; i < n; i++) begin
            ready = prep() == '0 ? 1'($urandom) : 1'b0;
            addr_in = AW'($urandom);
            addr_last = 1'($urandom);
            step();
        end
    endtask

    // pat: 0 = always ready, 1 = random ready, 2 = ready low for 2 cycles after the 2nd fetch
    task automatic run_packet(input int pat, input int rst_at);
        int w, len, fetched, paused, fc;
        w = pick();
        e_busy = 0; e_grant = '0; e_prio = '0; e_sop = 0; e_req = 0;
        ready = 1'b1;
        addr_in = AW'($urandom);
        addr_last = 1'($urandom);
        step();
        len = q[w].pop_front();
        grant_upd(w);
        e_busy = 1; e_grant = NP'(1) << w; e_prio = PW'(w); e_sop = 1; e_req = 1;
        ready = pat == 0 ? 1'b1 : 1'($urandom);
        addr_in = AW'($urandom);
        addr_last = len == 1;
        fetch_exp(len == 1);
        step();
        e_sop = 0;
        fetched = 1; paused = 0; fc = 0;
        while (fetched < len) begin
            fc++;
            addr_in = AW'($urandom);
            addr_last = fetched == len - 1;
            ready = pat == 1 ? ($urandom % 4 != 0) : !(pat == 2 && fetched == 2 && paused < 2);
            if (fc == rst_at) begin
                rst = 1'b1;
                ready = 1'b0;
                e_req = 0;
                step();
                rst = 1'b0;
                clear_all();
                m_ptr = NP - 1;
                m_cnt = 0;
                idle(LAT + 2);
                return;
            end
            if (!ready) paused++;
            e_req = ready;
            if (ready) begin
                fetch_exp(fetched == len - 1);
                fetched++;
            end
            step();
        end
        e_req = 0;
        for (int i = 0; i < LAT; i++) begin
            ready = 1'($urandom);
            addr_in = AW'($urandom);
            addr_last = 1'($urandom);
            step();
        end
    endtask

    task automatic flush_q();
        for (int p = 0; p < NP; p++) q[p].delete();
    endtask

    initial begin
        for (int i = 0; i < RING; i++) begin
            sv[i] = 1'b0; sl[i] = 1'b0; sd[i] = '0; sram_q[i] = '0;
        end
        for (int p = 0; p < NP; p++) wt[p] = 0;
        e_busy = 0; e_grant = '0; e_prio = '0; e_sop = 0; e_req = 0;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        idle(2);

        // SP, prepared = 0010_0110, single-beat packets
        mode = 1'b0;
        q[5].push_back(1); q[2].push_back(1); q[1].push_back(1);
        repeat (3) run_packet(0, 0);
        idle(2);

        // WRR with weights 7:3, 5:1, 2:2 and queues kept non-empty
        mode = 1'b1;
        wt[7] = 3; wt[5] = 1; wt[2] = 2;
        set_wt();
        for (int i = 0; i < 12; i++) begin
            q[7].push_back(1); q[5].push_back(1); q[2].push_back(1);
        end
        repeat (9) run_packet(0, 0);
        flush_q();

        // an SP grant re-centres the pointer, then p7 runs dry mid-quota and later returns
        mode = 1'b0;
        q[0].push_back(2);
        run_packet(0, 0);
        mode = 1'b1;
        q[7].push_back(1); q[7].push_back(1);
        for (int i = 0; i < 5; i++) begin
            q[5].push_back(1); q[2].push_back(1);
        end
        repeat (4) run_packet(0, 0);
        repeat (3) q[7].push_back(1);
        repeat (4) run_packet(0, 0);
        flush_q();

        // 4-beat packet with a 2-cycle ready pause after the 2nd fetch
        mode = 1'b0;
        q[4].push_back(4);
        run_packet(2, 0);
        idle(1);

        // reset in the 3rd FETCH cycle of an 8-beat packet; pointer must be back at NP-1
        mode = 1'b1;
        wt[3] = 2;
        set_wt();
        q[3].push_back(8);
        run_packet(0, 3);
        q[3].push_back(1); q[7].push_back(2); q[0].push_back(1);
        repeat (3) run_packet(1, 0);
        flush_q();

        // randomized traffic, modes and weights
        for (int k = 0; k < 40; k++) begin
            if (prep() == '0) begin
                for (int p = 0; p < NP; p++)
                    if ($urandom % 2 != 0)
                        repeat ($urandom_range(1, 3)) q[p].push_back($urandom_range(1, 6));
                if (prep() == '0) q[$urandom_range(0, NP - 1)].push_back($urandom_range(1, 6));
            end
            if ($urandom % 4 == 0) mode = 1'($urandom);
            if ($urandom % 6 == 0) begin
                for (int p = 0; p < NP; p++) wt[p] = $urandom_range(0, 4);
                set_wt();
            end
            run_packet(1, 0);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_read_scheduler.md
Name: pkt_read_scheduler

Overview:
- Packet-granular read scheduler for one SRAM controller output port.
- Picks one of NUM_PRIO priority queues, using either strict priority (SP) or per-priority weighted round robin (WRR) with an individual weight for each priority.
- Pulls packet addresses from the queue manager one at a time and issues the SRAM reads.
- Frames the returned data with sop/vld/eop and tolerates a configurable SRAM read latency.

Parameters:
NUM_PRIO, 8, number of priority queues
PRIO_W, 3, width of a priority index, equal to clog2(NUM_PRIO)
ADDR_W, 12, SRAM address width
DATA_W, 64, SRAM and output data width
WGT_W, 5, width of each WRR weight
RD_LAT, 1, SRAM read latency in cycles (at least 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mode  in  1  0 = SP, 1 = WRR; sampled only in IDLE
wrr_weight  in  NUM_PRIO*WGT_W  packed weights; priority p uses bits [p*WGT_W +: WGT_W]
ready  in  1  downstream go/pause
prepared  in  NUM_PRIO  queue p holds at least one complete packet
grant  out  NUM_PRIO  one-hot selected queue, held for the whole packet
addr_req  out  1  address pop strobe to the queue manager
addr_in  in  ADDR_W  address of the granted queue; valid while addr_req=1
addr_last  in  1  addr_in is the last beat of the packet
sram_en  out  1  SRAM read enable
sram_addr  out  ADDR_W  SRAM read address
sram_rdata  in  DATA_W  SRAM read data, RD_LAT cycles after sram_en
rd_sop  out  1  start-of-packet pulse
rd_vld  out  1  rd_data valid
rd_eop  out  1  end of packet, coincident with the last rd_vld beat
rd_data  out  DATA_W  packet data
rd_prio  out  PRIO_W  priority of the current packet
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. The WRR pointer is set to NUM_PRIO-1 and the WRR count to 0. The in-flight read pipeline is flushed, so a reset mid-packet drops the outstanding data and no eop is emitted.
- FSM states: IDLE, SOP, FETCH, DRAIN.
- IDLE: if ready=1 and prepared is non-zero, the winner is computed combinationally, registered into sel, and the FSM goes to SOP. prepared is not re-checked after IDLE; the queue manager guarantees a prepared queue holds a whole packet.
- SOP (exactly 1 cycle):
  - rd_sop=1.
  - grant=onehot(sel) and rd_prio=sel; both stay stable until the eop cycle inclusive.
  - First fetch issued: addr_req=1, sram_en=1.
  - Next state is FETCH, or DRAIN if addr_last=1.
- FETCH:
  - Each cycle with ready=1: addr_req=1, sram_en=1.
  - ready=0 pauses fetching (addr_req=0, sram_en=0), but reads already issued still return.
  - addr_req && addr_last moves the FSM to DRAIN.
- SRAM drive: sram_addr = addr_in, combinational, whenever sram_en=1.
- Read pipeline: a RD_LAT-deep shift of {valid, last}.
  - rd_vld=1 and rd_data=sram_rdata exactly RD_LAT cycles after each sram_en.
  - rd_eop=1 on the beat carrying the addr_last read. A 1-beat packet gets rd_eop on its only rd_vld beat.
  - Gaps in rd_vld appear only where the ready pause caused them.
- DRAIN: no fetches. Stay until the last beat is emitted, then go to IDLE on the next cycle. The earliest next rd_sop is therefore 2 cycles after rd_eop.
- grant is 0 in IDLE.
- SP mode:
  - Winner is the highest-index set bit of prepared.
  - On every SP grant the WRR pointer is set to NUM_PRIO-1 and the count to 0.
- WRR mode:
  - Winner is the first set bit of prepared, searching downward from the pointer and wrapping NUM_PRIO-1 -> 0.
  - On grant to queue w: n = (w==pointer ? count : 0) + 1. Weight 0 is treated as 1.
  - If n >= weight[w]: pointer = (w-1) mod NUM_PRIO, count = 0.
  - Otherwise: pointer = w, count = n.
  - Counting is in packets, not beats.
- Simultaneous events: ready falling in the same cycle as the winner is latched does not cancel the packet; the packet still begins with SOP.
- Changes to prepared or wrr_weight during a packet take effect at the next IDLE arbitration.

Test Plan:
- SP, prepared=8'b0010_0110, 1-beat packets -> grant order 0x20, 0x04, 0x02 (prepared updated by the model); each packet shows rd_sop, then rd_vld+rd_eop exactly RD_LAT cycles after its sram_en.
- WRR, weights p7=3, p5=1, p2=2, all others 0, prepared={7,5,2} held constant -> grant sequence 7,7,7,5,2,2,7,7,7,... per the packet-count rule.
- WRR, p7 empties after its 2nd of 3 packets -> next grant is 5; after one round p7 returns and gets a fresh count of 3.
- 4-beat packet, ready dropped for 2 cycles after the 2nd fetch -> addr_req and rd_vld each show a 2-cycle gap; 4 vld beats total; eop on beat 4 only; grant stable throughout.
- RD_LAT=3, 1-beat packet -> rd_vld=rd_eop=1 three cycles after the SOP cycle; FSM in IDLE the next cycle; next rd_sop no earlier than eop+2.
- rst asserted in the 3rd FETCH cycle of an 8-beat packet -> next cycle all outputs are 0, no rd_vld/rd_eop from in-flight reads, WRR pointer = NUM_PRIO-1.
